// File: rtl/fft_magnitude_estimator.sv
// fft_magnitude_estimator
//   Converts streaming FFT bins (two's complement real/imag) into unsigned
//   alpha-max-beta-min magnitude estimates, tagging each output with its bin
//   index and frame boundaries. Three-stage pipeline, one bin per cycle, no
//   backpressure.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   in_valid     input bin qualifier
//   in_sop       start of frame (bin 0), qualified by in_valid
//   in_real      signed real part, IN_WIDTH bits
//   in_imag      signed imaginary part, IN_WIDTH bits
//   out_valid    output qualifier
//   out_data     magnitude estimate, OUT_WIDTH bits
//   out_sop      high with out_valid on bin 0
//   out_eop      high with out_valid on bin FFT_SIZE-1
//   bin_index    bin number of out_data
//   frame_count  completed frames, wraps at 16 bits
//   sop_error    sticky flag for a premature in_sop
//
// Input-side FSM
//   state | meaning
//   IDLE  | waiting for in_sop; non-sop samples are dropped
//   RUN   | inside a frame; every in_valid sample is accepted at bin=cnt

module fft_magnitude_estimator #(
  parameter int IN_WIDTH   = 20,
  parameter int OUT_WIDTH  = 21,
  parameter int ADDR_WIDTH = 13,
  parameter int FFT_SIZE   = 8192
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_sop,
  input  logic [IN_WIDTH-1:0]   in_real,
  input  logic [IN_WIDTH-1:0]   in_imag,
  output logic                  out_valid,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [ADDR_WIDTH-1:0] bin_index,
  output logic [15:0]           frame_count,
  output logic                  sop_error
);

  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(FFT_SIZE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] cnt, cnt_next, in_bin;
  logic                  accept, in_eop, err_set;

  // Stage registers
  logic                  s1_valid, s1_sop, s1_eop;
  logic [ADDR_WIDTH-1:0] s1_bin;
  logic [IN_WIDTH-1:0]   s1_a, s1_b;
  logic                  s2_valid, s2_sop, s2_eop;
  logic [ADDR_WIDTH-1:0] s2_bin;
  logic [IN_WIDTH-1:0]   s2_mx, s2_mn;

  logic [IN_WIDTH-1:0]   abs_re, abs_im;
  logic [OUT_WIDTH-1:0]  mx_w, mn_w, e2, mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // An in_sop always restarts at bin 0; in RUN the counter is never 0, so
  // any sop seen there abandons the current frame.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    in_bin     = cnt;
    in_eop     = 1'b0;
    err_set    = 1'b0;
    if (in_valid) begin
      if (in_sop) begin
        accept  = 1'b1;
        in_bin  = '0;
        err_set = (state == RUN);
      end else if (state == RUN) begin
        accept = 1'b1;
      end
    end
    if (accept) begin
      in_eop = (in_bin == LAST_BIN);
      if (in_eop) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else begin
        state_next = RUN;
        cnt_next   = in_bin + ADDR_WIDTH'(1);
      end
    end
  end

  // Two's complement negate; the most negative value maps onto the unsigned
  // value 2^(IN_WIDTH-1), which still fits in IN_WIDTH bits.
  always_comb begin
    abs_re = in_real[IN_WIDTH-1] ? (~in_real + IN_WIDTH'(1)) : in_real;
    abs_im = in_imag[IN_WIDTH-1] ? (~in_imag + IN_WIDTH'(1)) : in_imag;
  end

  always_comb begin
    mx_w = OUT_WIDTH'(s2_mx);
    mn_w = OUT_WIDTH'(s2_mn);
    e2   = mx_w - (mx_w >> 3) + (mn_w >> 1);
    mag  = (e2 > mx_w) ? e2 : mx_w;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_sop      <= 1'b0;
      s1_eop      <= 1'b0;
      s1_bin      <= '0;
      s1_a        <= '0;
      s1_b        <= '0;
      s2_valid    <= 1'b0;
      s2_sop      <= 1'b0;
      s2_eop      <= 1'b0;
      s2_bin      <= '0;
      s2_mx       <= '0;
      s2_mn       <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sop     <= 1'b0;
      out_eop     <= 1'b0;
      bin_index   <= '0;
      frame_count <= '0;
      sop_error   <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_sop   <= accept & in_sop;
      s1_eop   <= in_eop;
      s1_bin   <= in_bin;
      s1_a     <= abs_re;
      s1_b     <= abs_im;

      s2_valid <= s1_valid;
      s2_sop   <= s1_sop;
      s2_eop   <= s1_eop;
      s2_bin   <= s1_bin;
      s2_mx    <= (s1_a >= s1_b) ? s1_a : s1_b;
      s2_mn    <= (s1_a >= s1_b) ? s1_b : s1_a;

      out_valid <= s2_valid;
      out_sop   <= s2_valid & s2_sop;
      out_eop   <= s2_valid & s2_eop;
      if (s2_valid) begin
        out_data  <= mag;
        bin_index <= s2_bin;
      end

      if (out_valid && out_eop)
        frame_count <= frame_count + 16'd1;
      if (err_set)
        sop_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_magnitude_estimator.sv
module tb_fft_magnitude_estimator;

  localparam int IW = 20;
  localparam int OW = 21;
  localparam int AW = 13;
  localparam int N  = 8192;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sop = 1'b0;
  logic [IW-1:0] in_real = '0;
  logic [IW-1:0] in_imag = '0;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_sop;
  logic          out_eop;
  logic [AW-1:0] bin_index;
  logic [15:0]   frame_count;
  logic          sop_error;

  fft_magnitude_estimator #(
    .IN_WIDTH(IW), .OUT_WIDTH(OW), .ADDR_WIDTH(AW), .FFT_SIZE(N)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop),
    .in_real(in_real), .in_imag(in_imag), .out_valid(out_valid),
    .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .bin_index(bin_index), .frame_count(frame_count), .sop_error(sop_error)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int     data;
    bit     sop;
    bit     eop;
    int     bin;
    longint cyc;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference frame tracking
  bit in_frame = 1'b0;
  int nxt = 0;
  int exp_fc = 0;
  bit exp_err = 1'b0;

  function automatic int ref_mag(int re, int im);
    int a, b, mx, mn, e2;
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    mx = (a > b) ? a : b;
    mn = (a > b) ? b : a;
    e2 = mx - mx / 8 + mn / 2;
    return (e2 > mx) ? e2 : mx;
  endfunction

  task automatic chk(string name, longint act, longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (sbq.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got bin %0d data %0d expected no output", bin_index, out_data);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_sop", out_sop, e.sop);
        chk("out_eop", out_eop, e.eop);
        chk("bin_index", bin_index, e.bin);
        chk("latency_cycle", cyc, e.cyc);
      end
    end else begin
      chk("idle_sop", out_sop, 0);
      chk("idle_eop", out_eop, 0);
    end
  end

  function automatic int rnd_s();
    int r;
    case ($urandom_range(15))
      0:       r = -(1 << (IW - 1));
      1:       r = (1 << (IW - 1)) - 1;
      2:       r = 0;
      default: r = int'($urandom_range((1 << IW) - 1)) - (1 << (IW - 1));
    endcase
    return r;
  endfunction

  task automatic send(bit v, bit s, int re, int im);
    int  bin;
    bit  acc;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = v;
    in_sop   = s;
    in_real  = IW'(re);
    in_imag  = IW'(im);
    acc = 1'b0;
    bin = 0;
    if (v) begin
      if (s) begin
        if (in_frame && nxt != 0) exp_err = 1'b1;
        acc = 1'b1;
        bin = 0;
      end else if (in_frame) begin
        acc = 1'b1;
        bin = nxt;
      end
    end
    if (acc) begin
      e.data = ref_mag(re, im);
      e.sop  = s;
      e.eop  = (bin == N - 1);
      e.bin  = bin;
      e.cyc  = cyc + 3;
      sbq.push_back(e);
      if (e.eop) begin
        in_frame = 1'b0;
        nxt      = 0;
        exp_fc   = (exp_fc + 1) % 65536;
      end else begin
        in_frame = 1'b1;
        nxt      = bin + 1;
      end
    end
  endtask

  task automatic idle();
    send(1'b0, 1'b0, rnd_s(), rnd_s());
  endtask

  task automatic drain();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    for (int i = 0; i < 8 && sbq.size() != 0; i++) @(negedge clk);
    chk("drain_timeout_pending", sbq.size(), 0);
  endtask

  task automatic status(string tag);
    chk({tag, "_frame_count"}, frame_count, exp_fc);
    chk({tag, "_sop_error"}, sop_error, exp_err);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    // Anything not yet out by the capturing edge is discarded by the DUT.
    while (sbq.size() > 0 && sbq[$].cyc > cyc) void'(sbq.pop_back());
    in_frame = 1'b0;
    nxt      = 0;
    exp_fc   = 0;
    exp_err  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_bin_index", bin_index, 0);
    chk("rst_out_sop", out_sop, 0);
    chk("rst_out_eop", out_eop, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_sop_error", sop_error, 0);
  endtask

  task automatic frame(int gap_pct);
    send(1'b1, 1'b1, rnd_s(), rnd_s());
    for (int b = 1; b < N; b++) begin
      while (int'($urandom_range(99)) < gap_pct) idle();
      send(1'b1, 1'b0, rnd_s(), rnd_s());
    end
  endtask

  int dir_re[4] = '{1000, -600, 3, -524288};
  int dir_im[4] = '{0, 800, 4, -524288};

  initial begin
    do_reset();

    for (int i = 0; i < 4; i++) begin
      do_reset();
      send(1'b1, 1'b1, dir_re[i], dir_im[i]);
      drain();
    end

    do_reset();
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0, rnd_s(), rnd_s());
    idle();
    frame(0);
    drain();
    status("full_frame");

    send(1'b1, 1'b1, rnd_s(), rnd_s());
    for (int b = 1; b < 100; b++) send(1'b1, 1'b0, rnd_s(), rnd_s());
    frame(0);
    drain();
    status("premature_sop");

    frame(0);
    frame(0);
    frame(10);
    frame(10);
    drain();
    status("back_to_back");

    send(1'b1, 1'b1, rnd_s(), rnd_s());
    for (int b = 1; b < 20; b++) send(1'b1, 1'b0, rnd_s(), rnd_s());
    do_reset();
    repeat (6) idle();
    status("after_reset");
    send(1'b1, 1'b0, rnd_s(), rnd_s());
    send(1'b1, 1'b1, rnd_s(), rnd_s());
    for (int b = 1; b < 10; b++) send(1'b1, 1'b0, rnd_s(), rnd_s());
    drain();
    status("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
